dadda_mac16: RTL and testbench

- Sequential multiply-accumulate stage built around the existing dadda16 combinational 16x16 multiplier.
- Accepts a stream of 16-bit operand pairs over a valid/ready handshake and registers each pair in front of dadda16.
- Accumulates the 32-bit products into a wide accumulator.
- On the beat flagged last, presents the sum and beat count downstream, held until consumed.

---
 rtl/dadda_mac16_pkg.sv | 25 ++
 rtl/dadda16.sv | 105 ++++++++++
 rtl/dadda_mac16.sv | 170 +++++++++++++++++
 tb/tb_dadda_mac16.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dadda_mac16_pkg.sv
// Shared constants and state encoding for the dadda_mac16 multiply-accumulate block
// and its dadda16 multiplier.
package dadda_mac16_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Dadda column-height targets, tallest stage first (16 -> 13 -> 9 -> 6 -> 4 -> 3 -> 2).
  function automatic logic [5:0] daddaHeight(input int stage);
    case (stage)
      0:       daddaHeight = 6'd13;
      1:       daddaHeight = 6'd9;
      2:       daddaHeight = 6'd6;
      3:       daddaHeight = 6'd4;
      4:       daddaHeight = 6'd3;
      default: daddaHeight = 6'd2;
    endcase
  endfunction

endpackage

// File: rtl/dadda16.sv
// Combinational 16x16 unsigned Dadda-tree multiplier: partial products are reduced
// column by column with half/full adders to two rows, then summed by one adder.
module dadda16
  import dadda_mac16_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] p_o
);

  localparam int COL_D = 32;

  logic [COL_D-1:0]  colBits [PROD_W];
  logic [5:0]        colCnt  [PROD_W];
  logic [COL_D-1:0]  nxtBits [PROD_W];
  logic [5:0]        nxtCnt  [PROD_W];
  logic [PROD_W-1:0] rowX;
  logic [PROD_W-1:0] rowY;

  always_comb begin
    logic [4:0] k5, kn5, r0, r1, r2;
    logic [5:0] rd, d, total;
    logic       x, y, z;

    for (int k = 0; k < PROD_W; k++) begin
      colBits[k] = '0;
      colCnt[k]  = '0;
      nxtBits[k] = '0;
      nxtCnt[k]  = '0;
    end
    k5 = '0; kn5 = '0; r0 = '0; r1 = '0; r2 = '0;
    rd = '0; d = '0; total = '0;
    x = 1'b0; y = 1'b0; z = 1'b0;
    rowX = '0;
    rowY = '0;

    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        k5 = 5'(i + j);
        colBits[k5][colCnt[k5][4:0]] = a_i[4'(i)] & b_i[4'(j)];
        colCnt[k5] = colCnt[k5] + 6'd1;
      end
    end

    for (int s = 0; s < 6; s++) begin
      d = daddaHeight(s);
      for (int k = 0; k < PROD_W; k++) begin
        nxtBits[k] = '0;
        nxtCnt[k]  = '0;
      end
      for (int k = 0; k < PROD_W; k++) begin
        k5  = 5'(k);
        kn5 = 5'(k + 1);
        rd  = '0;
        // Carries already landed in this column count toward its target height.
        for (int t = 0; t < 8; t++) begin
          total = colCnt[k5] - rd + nxtCnt[k5];
          r0 = rd[4:0];
          r1 = 5'(rd + 6'd1);
          r2 = 5'(rd + 6'd2);
          x  = colBits[k5][r0];
          y  = colBits[k5][r1];
          z  = colBits[k5][r2];
          if (total > d) begin
            if (total == d + 6'd1) begin
              nxtBits[k5][nxtCnt[k5][4:0]] = x ^ y;
              nxtCnt[k5] = nxtCnt[k5] + 6'd1;
              if (k < PROD_W - 1) begin
                nxtBits[kn5][nxtCnt[kn5][4:0]] = x & y;
                nxtCnt[kn5] = nxtCnt[kn5] + 6'd1;
              end
              rd = rd + 6'd2;
            end else begin
              nxtBits[k5][nxtCnt[k5][4:0]] = x ^ y ^ z;
              nxtCnt[k5] = nxtCnt[k5] + 6'd1;
              if (k < PROD_W - 1) begin
                nxtBits[kn5][nxtCnt[kn5][4:0]] = (x & y) | (x & z) | (y & z);
                nxtCnt[kn5] = nxtCnt[kn5] + 6'd1;
              end
              rd = rd + 6'd3;
            end
          end
        end
        for (int t = 0; t < COL_D; t++) begin
          if (6'(t) >= rd && 6'(t) < colCnt[k5]) begin
            nxtBits[k5][nxtCnt[k5][4:0]] = colBits[k5][5'(t)];
            nxtCnt[k5] = nxtCnt[k5] + 6'd1;
          end
        end
      end
      for (int k = 0; k < PROD_W; k++) begin
        colBits[k] = nxtBits[k];
        colCnt[k]  = nxtCnt[k];
      end
    end

    for (int k = 0; k < PROD_W; k++) begin
      rowX[5'(k)] = colBits[k][0];
      rowY[5'(k)] = colBits[k][1];
    end
  end

  assign p_o = rowX + rowY;

endmodule

// File: rtl/dadda_mac16.sv
// Streaming multiply-accumulate around dadda16; result held until consumed.
// Define DADDA_MAC_SAT_EN to saturate the accumulator and add the out_sat port.
module dadda_mac16
  import dadda_mac16_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt
`ifdef DADDA_MAC_SAT_EN
  ,
  output logic             out_sat
`endif
);

  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic              v1_q, v1_d;
  logic              last_q, last_d;
  logic              lastPending_q, lastPending_d;
  logic              outValid_q, outValid_d;
  logic [ACC_W-1:0]  acc_q, acc_d, outAcc_q, outAcc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, outCnt_q, outCnt_d;
  state_t            state_q, state_d;

  logic              accept;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prodExt;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  cntNext;
  logic              sumSat;

  dadda16 u_mult (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  assign accept  = in_valid && in_ready;
  assign prodExt = ACC_W'(prod);
  assign cntNext = cnt_q + CNT_W'(1);

`ifdef DADDA_MAC_SAT_EN
  logic             sat_q, sat_d, outSat_q, outSat_d;
  logic [ACC_W:0]   sumWide;

  // The sticky flag keeps a clamped sum clamped even if a later product is zero.
  assign sumWide = {1'b0, acc_q} + {1'b0, prodExt};
  assign sumSat  = sumWide[ACC_W] | sat_q;
  assign sum     = sumSat ? '1 : sumWide[ACC_W-1:0];
  assign out_sat = outSat_q;
`else
  assign sum    = acc_q + prodExt;
  assign sumSat = 1'b0;
`endif

  always_comb begin
    a_d           = a_q;
    b_d           = b_q;
    last_d        = last_q;
    v1_d          = accept;
    lastPending_d = lastPending_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    outAcc_d      = outAcc_q;
    outCnt_d      = outCnt_q;
    outValid_d    = outValid_q;
    state_d       = state_q;
`ifdef DADDA_MAC_SAT_EN
    sat_d         = sat_q;
    outSat_d      = outSat_q;
`endif

    if (accept) begin
      a_d    = in_a;
      b_d    = in_b;
      last_d = in_last;
      if (in_last) begin
        lastPending_d = 1'b1;
      end
    end

    case (state_q)
      ST_ACC: begin
        if (v1_q) begin
          if (!last_q) begin
            acc_d = sum;
            cnt_d = cntNext;
`ifdef DADDA_MAC_SAT_EN
            sat_d = sumSat;
`endif
          end else begin
            outAcc_d   = sum;
            outCnt_d   = cntNext;
            outValid_d = 1'b1;
            state_d    = ST_DONE;
`ifdef DADDA_MAC_SAT_EN
            outSat_d   = sumSat;
`endif
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          acc_d         = '0;
          cnt_d         = '0;
          lastPending_d = 1'b0;
          outValid_d    = 1'b0;
          state_d       = ST_ACC;
`ifdef DADDA_MAC_SAT_EN
          sat_d         = 1'b0;
          outSat_d      = 1'b0;
`endif
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      v1_q          <= 1'b0;
      last_q        <= 1'b0;
      lastPending_q <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      outAcc_q      <= '0;
      outCnt_q      <= '0;
      outValid_q    <= 1'b0;
      state_q       <= ST_ACC;
`ifdef DADDA_MAC_SAT_EN
      sat_q         <= 1'b0;
      outSat_q      <= 1'b0;
`endif
    end else begin
      a_q           <= a_d;
      b_q           <= b_d;
      v1_q          <= v1_d;
      last_q        <= last_d;
      lastPending_q <= lastPending_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      outAcc_q      <= outAcc_d;
      outCnt_q      <= outCnt_d;
      outValid_q    <= outValid_d;
      state_q       <= state_d;
`ifdef DADDA_MAC_SAT_EN
      sat_q         <= sat_d;
      outSat_q      <= outSat_d;
`endif
    end
  end

  assign in_ready  = !lastPending_q;
  assign out_valid = outValid_q;
  assign out_acc   = outAcc_q;
  assign out_cnt   = outCnt_q;

endmodule

// File: tb/tb_dadda_mac16.sv
// Directed self-checking bench for dadda_mac16 at ACC_W=32; expects saturation
// results when DADDA_MAC_SAT_EN is defined.
module tb_dadda_mac16;
  import dadda_mac16_pkg::*;

  localparam int ACC_W = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_cnt;
`ifdef DADDA_MAC_SAT_EN
  logic             out_sat;
`endif

  int errorCount = 0;
  int checkCount = 0;

  dadda_mac16 #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt)
`ifdef DADDA_MAC_SAT_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents one beat for exactly one rising edge; back-to-back calls give 1 beat/clock.
  task automatic applyStimulus(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic last);
    checkOutput("in_ready_before_beat", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshakeResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("out_valid_after_hs", 64'(out_valid), 64'd0);
    checkOutput("in_ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_acc", 64'(out_acc), 64'd0);
    checkOutput("rst_out_cnt", 64'(out_cnt), 64'd0);

    $display("[TB] single last beat");
    applyStimulus(16'd1500, 16'd198, 1'b1);
    checkOutput("single_valid_early", 64'(out_valid), 64'd0);
    checkOutput("single_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("single_valid", 64'(out_valid), 64'd1);
    checkOutput("single_acc", 64'(out_acc), 64'd297000);
    checkOutput("single_cnt", 64'(out_cnt), 64'd1);
`ifdef DADDA_MAC_SAT_EN
    checkOutput("single_sat", 64'(out_sat), 64'd0);
`endif
    handshakeResult();

    $display("[TB] back-to-back stream with backpressure");
    applyStimulus(16'd60000, 16'd60000, 1'b0);
    applyStimulus(16'd4095, 16'd4095, 1'b1);
    checkOutput("b2b_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("b2b_valid", 64'(out_valid), 64'd1);
    checkOutput("b2b_acc", 64'(out_acc), 64'd3616769025);
    checkOutput("b2b_cnt", 64'(out_cnt), 64'd2);
    in_valid = 1'b1;
    in_a     = 16'd7;
    in_b     = 16'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_acc", 64'(out_acc), 64'd3616769025);
      checkOutput("bp_cnt", 64'(out_cnt), 64'd2);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    end
    handshakeResult();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("bp_next_valid_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("bp_next_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_next_acc", 64'(out_acc), 64'd49);
    checkOutput("bp_next_cnt", 64'(out_cnt), 64'd1);
    handshakeResult();

    $display("[TB] overflow of the 32-bit accumulator");
    applyStimulus(16'd65535, 16'd65535, 1'b0);
    applyStimulus(16'd65535, 16'd65535, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("ovf_valid", 64'(out_valid), 64'd1);
`ifdef DADDA_MAC_SAT_EN
    checkOutput("ovf_acc", 64'(out_acc), 64'hFFFF_FFFF);
    checkOutput("ovf_sat", 64'(out_sat), 64'd1);
`else
    checkOutput("ovf_acc", 64'(out_acc), 64'd4294705154);
`endif
    checkOutput("ovf_cnt", 64'(out_cnt), 64'd2);
    handshakeResult();

    $display("[TB] reset mid-operation");
    applyStimulus(16'd5445, 16'd564, 1'b0);
    applyStimulus(16'd154, 16'd10786, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_acc", 64'(out_acc), 64'd0);
    applyStimulus(16'd3, 16'd4, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("midrst_valid", 64'(out_valid), 64'd1);
    checkOutput("midrst_acc", 64'(out_acc), 64'd12);
    checkOutput("midrst_cnt", 64'(out_cnt), 64'd1);
`ifdef DADDA_MAC_SAT_EN
    checkOutput("midrst_sat", 64'(out_sat), 64'd0);
`endif
    handshakeResult();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
